// File: rtl/smi_rx_burst_arbiter_pkg.sv
// Shared definitions for the SMI RX burst arbiter: state encoding, channel ids
// and the tag byte layout that host software uses to demultiplex bursts.
package smi_rx_burst_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HDR   = 3'd1,
      ST_PULL  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_SHIFT = 3'd4
   } arbState_t;

   localparam logic CH_09 = 1'b0;
   localparam logic CH_24 = 1'b1;

   // Tag byte: [7:4] fixed nibble, [3:1] reserved zero, [0] channel id
   localparam int TAG_NIBBLE_LSB = 4;
   localparam int TAG_CH_BIT     = 0;

   function automatic logic [7:0] makeTag(input logic [3:0] nibble, input logic ch);
      return {nibble, 3'b000, ch};
   endfunction

endpackage

// File: rtl/smi_rx_burst_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; remembers the last served requester and
// favours the other one on a tie.
module rr_arb2 (
   input  logic       sysClk_i,
   input  logic       reset_i,
   input  logic [1:0] req_i,
   input  logic       advance_i,
   output logic       grant_o,
   output logic       grantValid_o
);

   logic lastServed_q;
   logic lastServed_d;

   always_comb begin
      grantValid_o = |req_i;
      grant_o      = req_i[1];
      if (&req_i) begin
         grant_o = ~lastServed_q;
      end
      lastServed_d = lastServed_q;
      if (advance_i && grantValid_o) begin
         lastServed_d = grant_o;
      end
   end

   // Reset to 1 so that channel 0 wins the first tie
   always_ff @(posedge sysClk_i) begin
      if (reset_i) begin
         lastServed_q <= 1'b1;
      end else begin
         lastServed_q <= lastServed_d;
      end
   end

endmodule

// File: rtl/smi_rx_burst_arbiter.sv
// Shares the SMI read byte stream between the 0.9 GHz and 2.4 GHz RX FIFOs:
// tagged bursts of 32-bit words, serialized MSB-first with stall timeout.
module smi_rx_burst_arbiter
   import smi_rx_burst_arbiter_pkg::*;
#(
   parameter int         BURST_WORDS   = 16,
   parameter int         STALL_TIMEOUT = 64,
   parameter logic [3:0] TAG_NIBBLE    = 4'hA
) (
   input  logic        i_sys_clk,
   input  logic        i_reset,
   input  logic [1:0]  i_ch_en,
   output logic        o_fifo_09_pull,
   input  logic [31:0] i_fifo_09_data,
   input  logic        i_fifo_09_empty,
   output logic        o_fifo_24_pull,
   input  logic [31:0] i_fifo_24_data,
   input  logic        i_fifo_24_empty,
   input  logic        i_byte_rd,
   output logic [7:0]  o_byte,
   output logic        o_byte_valid,
   output logic        o_active_ch,
   output logic        o_busy,
   output logic        o_read_req,
   output logic        o_underrun,
   input  logic        i_clear_err,
   output logic [15:0] o_burst_cnt
);

   localparam logic [7:0] BURST_LEN   = 8'(BURST_WORDS);
   localparam logic [7:0] STALL_LIMIT = 8'(STALL_TIMEOUT);

   arbState_t   state_q,    state_d;
   logic        activeCh_q, activeCh_d;
   logic [31:0] shift_q,    shift_d;
   logic [7:0]  byte_q,     byte_d;
   logic [1:0]  byteIdx_q,  byteIdx_d;
   logic [7:0]  wordCnt_q,  wordCnt_d;
   logic [7:0]  stallCnt_q, stallCnt_d;
   logic        underrun_q, underrun_d;
   logic [15:0] burstCnt_q, burstCnt_d;

   logic [1:0]  eligible;
   logic        grant;
   logic        grantValid;
   logic        activeEmpty;
   logic [31:0] activeData;
   logic        pullReq;
   logic        underrunSet;

   assign eligible    = i_ch_en & {~i_fifo_24_empty, ~i_fifo_09_empty};
   assign activeEmpty = (activeCh_q == CH_24) ? i_fifo_24_empty : i_fifo_09_empty;
   assign activeData  = (activeCh_q == CH_24) ? i_fifo_24_data  : i_fifo_09_data;

   rr_arb2 u_arb (
      .sysClk_i     (i_sys_clk),
      .reset_i      (i_reset),
      .req_i        (eligible),
      .advance_i    (state_q == ST_IDLE),
      .grant_o      (grant),
      .grantValid_o (grantValid)
   );

   always_comb begin
      state_d     = state_q;
      activeCh_d  = activeCh_q;
      shift_d     = shift_q;
      byte_d      = byte_q;
      byteIdx_d   = byteIdx_q;
      wordCnt_d   = wordCnt_q;
      stallCnt_d  = stallCnt_q;
      burstCnt_d  = burstCnt_q;
      pullReq     = 1'b0;
      underrunSet = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (grantValid) begin
               activeCh_d = grant;
               byte_d     = makeTag(TAG_NIBBLE, grant);
               state_d    = ST_HDR;
            end
         end
         ST_HDR: begin
            if (i_byte_rd) begin
               wordCnt_d  = 8'd0;
               stallCnt_d = 8'd0;
               state_d    = ST_PULL;
            end
         end
         // Only the active channel's emptiness matters; enables are not re-checked mid-burst
         ST_PULL: begin
            if (!activeEmpty) begin
               pullReq    = 1'b1;
               stallCnt_d = 8'd0;
               state_d    = ST_WAIT;
            end else if (stallCnt_q + 8'd1 == STALL_LIMIT) begin
               underrunSet = 1'b1;
               stallCnt_d  = 8'd0;
               state_d     = ST_IDLE;
            end else begin
               stallCnt_d = stallCnt_q + 8'd1;
            end
         end
         ST_WAIT: begin
            shift_d   = activeData;
            byte_d    = activeData[31:24];
            byteIdx_d = 2'd0;
            state_d   = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (i_byte_rd) begin
               if (byteIdx_q == 2'd3) begin
                  wordCnt_d = wordCnt_q + 8'd1;
                  if (wordCnt_q + 8'd1 == BURST_LEN) begin
                     burstCnt_d = burstCnt_q + 16'd1;
                     state_d    = ST_IDLE;
                  end else begin
                     state_d = ST_PULL;
                  end
               end else begin
                  byteIdx_d = byteIdx_q + 2'd1;
                  byte_d    = shift_q[23:16];
                  shift_d   = {shift_q[23:0], 8'h00};
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      underrun_d = underrun_q;
      if (underrunSet) begin
         underrun_d = 1'b1;
      end else if (i_clear_err) begin
         underrun_d = 1'b0;
      end
   end

   always_ff @(posedge i_sys_clk) begin
      if (i_reset) begin
         state_q    <= ST_IDLE;
         activeCh_q <= 1'b0;
         shift_q    <= '0;
         byte_q     <= '0;
         byteIdx_q  <= '0;
         wordCnt_q  <= '0;
         stallCnt_q <= '0;
         underrun_q <= 1'b0;
         burstCnt_q <= '0;
      end else begin
         state_q    <= state_d;
         activeCh_q <= activeCh_d;
         shift_q    <= shift_d;
         byte_q     <= byte_d;
         byteIdx_q  <= byteIdx_d;
         wordCnt_q  <= wordCnt_d;
         stallCnt_q <= stallCnt_d;
         underrun_q <= underrun_d;
         burstCnt_q <= burstCnt_d;
      end
   end

   // Pulls are gated by reset so a reset landing in PULL never pops a word
   assign o_fifo_09_pull = pullReq && (activeCh_q == CH_09) && !i_reset;
   assign o_fifo_24_pull = pullReq && (activeCh_q == CH_24) && !i_reset;

   assign o_byte       = byte_q;
   assign o_byte_valid = (state_q == ST_HDR) || (state_q == ST_SHIFT);
   assign o_active_ch  = activeCh_q;
   assign o_busy       = (state_q != ST_IDLE);
   assign o_read_req   = o_byte_valid || (|eligible);
   assign o_underrun   = underrun_q;
   assign o_burst_cnt  = burstCnt_q;

endmodule

// File: tb/tb_smi_rx_burst_arbiter.sv
// Directed bench for smi_rx_burst_arbiter with two model FIFOs (registered read
// data, one cycle after pull) and a pull-strobe monitor.
module tb_smi_rx_burst_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  chEn = 2'b00;
   logic        pull09;
   logic        pull24;
   logic [31:0] data09 = '0;
   logic [31:0] data24 = '0;
   logic        empty09;
   logic        empty24;
   logic        byteRd = 1'b0;
   logic [7:0]  outByte;
   logic        byteValid;
   logic        activeCh;
   logic        busy;
   logic        readReq;
   logic        underrun;
   logic        clearErr = 1'b0;
   logic [15:0] burstCnt;

   logic [31:0] mem09 [256];
   logic [31:0] mem24 [256];
   int          wr09 = 0, rd09 = 0, wr24 = 0, rd24 = 0;
   logic        flush09 = 1'b0;
   logic        flush24 = 1'b0;
   logic        pullPrev09 = 1'b0;
   logic        pullPrev24 = 1'b0;
   int          pullCnt09 = 0, pullCnt24 = 0;
   int          pullWideErr = 0, pullEmptyErr = 0;

   int          testsRun = 0;
   int          failCount = 0;
   int          pullBase;

   assign empty09 = (wr09 == rd09);
   assign empty24 = (wr24 == rd24);

   always #5 clk = ~clk;

   smi_rx_burst_arbiter #(
      .BURST_WORDS   (2),
      .STALL_TIMEOUT (8),
      .TAG_NIBBLE    (4'hA)
   ) dut (
      .i_sys_clk       (clk),
      .i_reset         (rst),
      .i_ch_en         (chEn),
      .o_fifo_09_pull  (pull09),
      .i_fifo_09_data  (data09),
      .i_fifo_09_empty (empty09),
      .o_fifo_24_pull  (pull24),
      .i_fifo_24_data  (data24),
      .i_fifo_24_empty (empty24),
      .i_byte_rd       (byteRd),
      .o_byte          (outByte),
      .o_byte_valid    (byteValid),
      .o_active_ch     (activeCh),
      .o_busy          (busy),
      .o_read_req      (readReq),
      .o_underrun      (underrun),
      .i_clear_err     (clearErr),
      .o_burst_cnt     (burstCnt)
   );

   // FIFO read side plus pull-pulse monitoring
   always @(posedge clk) begin
      pullPrev09 <= pull09;
      pullPrev24 <= pull24;
      if ((pull09 && pullPrev09) || (pull24 && pullPrev24)) pullWideErr <= pullWideErr + 1;
      if ((pull09 && empty09) || (pull24 && empty24)) pullEmptyErr <= pullEmptyErr + 1;
      if (pull09) pullCnt09 <= pullCnt09 + 1;
      if (pull24) pullCnt24 <= pullCnt24 + 1;
      if (flush09) begin
         rd09 <= wr09;
      end else if (pull09) begin
         data09 <= mem09[rd09[7:0]];
         rd09   <= rd09 + 1;
      end
      if (flush24) begin
         rd24 <= wr24;
      end else if (pull24) begin
         data24 <= mem24[rd24[7:0]];
         rd24   <= rd24 + 1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic pushWord(input logic ch, input logic [31:0] word);
      if (ch) begin
         mem24[wr24[7:0]] = word;
         wr24++;
      end else begin
         mem09[wr09[7:0]] = word;
         wr09++;
      end
   endtask

   task automatic flushFifo(input logic ch);
      if (ch) flush24 = 1'b1;
      else    flush09 = 1'b1;
      @(negedge clk);
      flush09 = 1'b0;
      flush24 = 1'b0;
   endtask

   // Consume one byte: idle two cycles, wait for valid, check it, pulse i_byte_rd
   task automatic applyStimulus(input string tag, input logic [7:0] expected);
      int waited;
      repeat (2) @(negedge clk);
      waited = 0;
      while (!byteValid && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      if (!byteValid) begin
         checkOutput({tag, "_timeout"}, {31'd0, byteValid}, 32'd1);
      end else begin
         checkOutput(tag, {24'd0, outByte}, {24'd0, expected});
         byteRd = 1'b1;
         @(negedge clk);
         byteRd = 1'b0;
      end
   endtask

   task automatic readWord(input string tag, input logic [31:0] word);
      applyStimulus($sformatf("%s_b0", tag), word[31:24]);
      applyStimulus($sformatf("%s_b1", tag), word[23:16]);
      applyStimulus($sformatf("%s_b2", tag), word[15:8]);
      applyStimulus($sformatf("%s_b3", tag), word[7:0]);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not complete");
      $fatal(1, "[TB] global timeout");
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("rst_valid",    {31'd0, byteValid}, 32'd0);
      checkOutput("rst_busy",     {31'd0, busy},      32'd0);
      checkOutput("rst_readreq",  {31'd0, readReq},   32'd0);
      checkOutput("rst_underrun", {31'd0, underrun},  32'd0);
      checkOutput("rst_activech", {31'd0, activeCh},  32'd0);
      checkOutput("rst_byte",     {24'd0, outByte},   32'd0);
      checkOutput("rst_burstcnt", {16'd0, burstCnt},  32'd0);
      checkOutput("rst_pulls",    {30'd0, pull24, pull09}, 32'd0);

      // Both channels, two-word bursts, ch0 first then ch1
      pushWord(1'b0, 32'h01020304);
      pushWord(1'b0, 32'h05060708);
      pushWord(1'b1, 32'h8899AABB);
      pushWord(1'b1, 32'hCCDDEEFF);
      chEn = 2'b11;
      rst  = 1'b0;
      applyStimulus("t1_tag0", 8'hA0);
      checkOutput("t1_active0", {31'd0, activeCh}, 32'd0);
      readWord("t1_c0w0", 32'h01020304);
      readWord("t1_c0w1", 32'h05060708);
      checkOutput("t1_cnt1", {16'd0, burstCnt}, 32'd1);
      applyStimulus("t1_tag1", 8'hA1);
      checkOutput("t1_active1", {31'd0, activeCh}, 32'd1);
      readWord("t1_c1w0", 32'h8899AABB);
      readWord("t1_c1w1", 32'hCCDDEEFF);
      checkOutput("t1_cnt2",    {16'd0, burstCnt}, 32'd2);
      checkOutput("t1_pulls09", pullCnt09, 32'd2);
      @(negedge clk);
      checkOutput("t1_idle", {31'd0, busy}, 32'd0);

      // Only ch1 enabled; ch0 holds a word that must be ignored
      chEn = 2'b00;
      pushWord(1'b0, 32'hDEADBEEF);
      pushWord(1'b1, 32'h11223344);
      pushWord(1'b1, 32'h55667788);
      pullBase = pullCnt24;
      chEn = 2'b10;
      applyStimulus("t2_tag", 8'hA1);
      readWord("t2_w0", 32'h11223344);
      readWord("t2_w1", 32'h55667788);
      checkOutput("t2_pulls24", pullCnt24 - pullBase, 32'd2);
      checkOutput("t2_pulls09", pullCnt09, 32'd2);
      checkOutput("t2_cnt",     {16'd0, burstCnt}, 32'd3);
      chEn = 2'b00;
      flushFifo(1'b0);

      // ch0 runs dry after one word: timeout after 8 PULL cycles
      pushWord(1'b0, 32'hCAFEF00D);
      chEn = 2'b01;
      applyStimulus("t3_tag", 8'hA0);
      readWord("t3_w0", 32'hCAFEF00D);
      repeat (7) @(negedge clk);
      checkOutput("t3_still_busy",   {31'd0, busy},     32'd1);
      checkOutput("t3_no_underrun",  {31'd0, underrun}, 32'd0);
      @(negedge clk);
      checkOutput("t3_idle",         {31'd0, busy},     32'd0);
      checkOutput("t3_underrun",     {31'd0, underrun}, 32'd1);
      checkOutput("t3_cnt_same",     {16'd0, burstCnt}, 32'd3);
      repeat (3) @(negedge clk);
      checkOutput("t3_sticky",       {31'd0, underrun}, 32'd1);
      clearErr = 1'b1;
      @(negedge clk);
      clearErr = 1'b0;
      checkOutput("t3_cleared",      {31'd0, underrun}, 32'd0);

      // Byte reads during PULL/WAIT are ignored
      pushWord(1'b0, 32'h13579BDF);
      pushWord(1'b0, 32'h2468ACE0);
      applyStimulus("t4_tag", 8'hA0);
      readWord("t4_w0", 32'h13579BDF);
      byteRd = 1'b1;
      @(negedge clk);
      checkOutput("t4_novalid_wait", {31'd0, byteValid}, 32'd0);
      @(negedge clk);
      byteRd = 1'b0;
      checkOutput("t4_valid_after",  {31'd0, byteValid}, 32'd1);
      checkOutput("t4_first_byte",   {24'd0, outByte},   32'h24);
      readWord("t4_w1", 32'h2468ACE0);
      checkOutput("t4_cnt", {16'd0, burstCnt}, 32'd4);

      // ch0 disabled mid-burst: burst still completes, then ch1 only
      chEn = 2'b00;
      pushWord(1'b0, 32'h10203040);
      pushWord(1'b0, 32'h50607080);
      pushWord(1'b0, 32'h90A0B0C0);
      chEn = 2'b01;
      applyStimulus("t5_tag0", 8'hA0);
      pushWord(1'b1, 32'h0F1E2D3C);
      pushWord(1'b1, 32'h4B5A6978);
      chEn = 2'b10;
      readWord("t5_c0w0", 32'h10203040);
      readWord("t5_c0w1", 32'h50607080);
      applyStimulus("t5_tag1", 8'hA1);
      readWord("t5_c1w0", 32'h0F1E2D3C);
      readWord("t5_c1w1", 32'h4B5A6978);
      checkOutput("t5_cnt", {16'd0, burstCnt}, 32'd6);
      chEn = 2'b00;
      flushFifo(1'b0);

      // Reset mid-burst while byte 2 of a word is presented
      pushWord(1'b0, 32'hA1B2C3D4);
      pushWord(1'b0, 32'hE5F60718);
      pushWord(1'b0, 32'h293A4B5C);
      pushWord(1'b1, 32'h6D7E8F90);
      pushWord(1'b1, 32'h0112EEFF);
      chEn = 2'b11;
      applyStimulus("t6_tag_pre", 8'hA0);
      applyStimulus("t6_pre_b0", 8'hA1);
      applyStimulus("t6_pre_b1", 8'hB2);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("t6_rst_valid", {31'd0, byteValid}, 32'd0);
      checkOutput("t6_rst_pulls", {30'd0, pull24, pull09}, 32'd0);
      checkOutput("t6_rst_cnt",   {16'd0, burstCnt},  32'd0);
      checkOutput("t6_rst_busy",  {31'd0, busy},      32'd0);
      rst = 1'b0;
      applyStimulus("t6_tag0", 8'hA0);
      readWord("t6_c0w1", 32'hE5F60718);
      readWord("t6_c0w2", 32'h293A4B5C);
      applyStimulus("t6_tag1", 8'hA1);
      readWord("t6_c1w0", 32'h6D7E8F90);
      readWord("t6_c1w1", 32'h0112EEFF);
      checkOutput("t6_cnt", {16'd0, burstCnt}, 32'd2);

      // Pull discipline over the whole run
      @(negedge clk);
      checkOutput("pull_single_cycle", pullWideErr,  32'd0);
      checkOutput("pull_never_empty",  pullEmptyErr, 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule

// File: doc/smi_rx_burst_arbiter.md
Name: smi_rx_burst_arbiter

Overview:
Shares the single SMI read byte stream between the 0.9 GHz and 2.4 GHz RX sample FIFOs (32-bit words each).
- Grants channels round-robin, one burst per grant.
- Frames each burst with a tag byte so the host can demultiplex.
- Serializes each 32-bit word MSB-first into bytes, with stall handling and underrun reporting.
- Sits between the two RX FIFOs and the SMI pad/strobe logic; strobes reach it already synchronized to i_sys_clk.

Parameters:
BURST_WORDS, 16, 32-bit words per burst (1..255)
STALL_TIMEOUT, 64, cycles to wait on an empty FIFO mid-burst before aborting (1..255)
TAG_NIBBLE, 4'hA, upper nibble of the burst tag byte

Ports:
i_sys_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_ch_en  in  2  per-channel enable; bit0 = 0.9 GHz, bit1 = 2.4 GHz
o_fifo_09_pull  out  1  one-cycle pull strobe; data valid the next cycle
i_fifo_09_data  in  32  0.9 GHz FIFO read data
i_fifo_09_empty  in  1  0.9 GHz FIFO empty
o_fifo_24_pull  out  1  as above, 2.4 GHz
i_fifo_24_data  in  32  as above, 2.4 GHz
i_fifo_24_empty  in  1  as above, 2.4 GHz
i_byte_rd  in  1  single-cycle host byte-consume strobe
o_byte  out  8  current output byte
o_byte_valid  out  1  o_byte holds an unconsumed byte
o_active_ch  out  1  channel of the current burst
o_busy  out  1  burst in progress (state != IDLE)
o_read_req  out  1  data pending for host
o_underrun  out  1  sticky: a burst was aborted on timeout
i_clear_err  in  1  clears o_underrun
o_burst_cnt  out  16  completed bursts, wraps at 0xFFFF

Behaviour:
Reset values:
- All outputs 0.
- Internal last_served = 1, so channel 0 wins the first tie.
- All counters 0; state IDLE.

States: IDLE, HDR, PULL, WAIT, SHIFT.

Eligibility: ch eligible = i_ch_en[ch] && !empty[ch].

IDLE:
- If any channel is eligible, pick a winner and register it into o_active_ch.
- Both eligible: winner = !last_served.
- One eligible: that one.
- Update last_served and go to HDR.

HDR:
- Load o_byte = {TAG_NIBBLE, 3'b000, ch}; o_byte_valid = 1.
- On i_byte_rd, clear word count and go to PULL.

PULL:
- If FIFO[ch] is not empty: assert its pull for exactly 1 cycle, clear the stall counter, go to WAIT.
- If empty: increment the stall counter; at STALL_TIMEOUT set o_underrun and go to IDLE.
  - The aborted burst is not counted in o_burst_cnt.
  - Any in-flight pulled data is never pulled.

WAIT:
- One cycle; latch FIFO data into a 32-bit shift register.
- Load o_byte = data[31:24]; set o_byte_valid; byte index = 0; go to SHIFT.

SHIFT:
- Each i_byte_rd while o_byte_valid advances to the next byte: [23:16], [15:8], [7:0].
- After the consume of byte index 3, increment the word count:
  - word count == BURST_WORDS → o_burst_cnt++, go to IDLE.
  - otherwise go to PULL.
- o_byte_valid = 0 in PULL, WAIT and IDLE.

Latency:
- Consume of the last byte of a word → next word's first byte valid 2 cycles later (PULL, WAIT) when the FIFO is non-empty.
- IDLE → tag valid: 1 cycle.

Strobe and control rules:
- i_byte_rd while !o_byte_valid is ignored; no state change.
- Never more than one pull per word; never pull an empty FIFO.
- i_ch_en changes take effect only at IDLE arbitration; a burst in progress always completes or times out.
- o_read_req = o_byte_valid || any channel eligible (combinational).
- i_clear_err and an underrun event in the same cycle: the set wins.
- Reset mid-burst: immediately returns to IDLE with reset values; no pull is asserted in the reset cycle.

Decomposition:
Shared package (smi_pkg):
- State encoding (3-bit localparams).
- Channel ids CH_09 = 0, CH_24 = 1.
- Tag byte layout constants, shared with host software docs.

Sub-module rr_arb2:
- Two-requester round-robin.
- Inputs: req[1:0], advance, reset. Outputs: grant, grant_valid.
- Owns last_served.

Test Plan:
- Both FIFOs hold ≥32 words, BURST_WORDS = 2, i_byte_rd every 3rd cycle → stream A0, 4 bytes of ch0 word0 MSB-first, 4 bytes of ch0 word1, A1, ch1 words; o_burst_cnt reaches 2.
- Only ch1 enabled, FIFO word 0x11223344 → bytes A1, 11, 22, 33, 44; exactly one o_fifo_24_pull pulse per word, each 1 cycle.
- ch0 FIFO empties after 1 of 2 words, STALL_TIMEOUT = 8 → state returns to IDLE 8 cycles after PULL entry; o_underrun = 1; o_burst_cnt unchanged; i_clear_err clears it.
- i_byte_rd pulses with o_byte_valid = 0 (during WAIT) → ignored; no byte skipped, word bytes still arrive in order.
- i_ch_en cleared for ch0 mid-burst → burst completes all BURST_WORDS words; next grant goes to ch1 only.
- Assert i_reset during SHIFT of byte 2 → next cycle o_byte_valid = 0, pulls = 0, o_burst_cnt = 0; after release the first tag is A0 when both channels are eligible.
